// File: rtl/dino_obstacle_rng.sv
// dino_obstacle_rng
//
// Pseudo-random obstacle selector for the Dino game. A free-running 16-bit
// Fibonacci LFSR (x^16+x^14+x^13+x^11+1) is sampled when a request is
// accepted. The sampled word is then reduced modulo MOD by shifting it through
// the remainder register one bit per cycle, MSB first. The result is offered to
// the obstacle spawner through a valid/ack handshake.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset_n    asynchronous active-low reset
//   seed_load  load seed_in (or SEED if seed_in is zero) into the LFSR
//   seed_in    seed value
//   req        request a new value, accepted only while busy is low
//   busy       high while a value is being reduced or waiting for ack
//   out_valid  value is valid, held until ack
//   value      random value in 0..MOD-1
//   ack        consumer accepts value
//   lfsr_q     current LFSR state
//
// Latency: a req accepted at edge t gives out_valid after edge t+16.
// The tap set is fixed, so WIDTH must stay at 16.

module dino_obstacle_rng #(
    parameter int               WIDTH = 16,
    parameter int               MOD   = 3,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter int               VW    = $clog2(MOD)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    output logic             busy,
    output logic             out_valid,
    output logic [VW-1:0]    value,
    input  logic             ack,
    output logic [WIDTH-1:0] lfsr_q
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REDUCE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    // Modulus at the width of the doubled remainder.
    localparam logic [VW:0]   MOD_W    = (VW + 1)'(MOD);

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] lfsr_reg;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] eff_seed;
    logic [WIDTH-1:0] work_reg;
    logic [VW-1:0]    rem_reg;
    logic [VW-1:0]    rem_next;
    logic [VW:0]      rem_dbl;
    logic [CW-1:0]    cnt_reg;
    logic [VW-1:0]    value_reg;
    logic             valid_reg;
    logic             busy_reg;

    // A zero seed would lock the LFSR, so it is replaced by SEED.
    assign eff_seed  = (seed_in == '0) ? SEED : seed_in;
    assign lfsr_next = {lfsr_reg[WIDTH-2:0],
                        lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

    // rem < MOD, so 2*rem + bit < 2*MOD and one conditional subtract suffices.
    assign rem_dbl  = {rem_reg, work_reg[WIDTH-1]};
    assign rem_next = (rem_dbl >= MOD_W) ? VW'(rem_dbl - MOD_W) : rem_dbl[VW-1:0];

    // LFSR: free-running, seed load takes priority over the advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_reg <= SEED;
        end else if (seed_load) begin
            lfsr_reg <= eff_seed;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    // Request / reduce / handshake sequencer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            value_reg <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        // A same-cycle seed load is visible to this request.
                        work_reg  <= seed_load ? eff_seed : lfsr_reg;
                        rem_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= REDUCE;
                    end
                end
                REDUCE: begin
                    rem_reg  <= rem_next;
                    work_reg <= work_reg << 1;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        value_reg <= rem_next;
                        valid_reg <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (ack) begin
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign out_valid = valid_reg;
    assign value     = value_reg;
    assign lfsr_q    = lfsr_reg;

endmodule
